// File: rtl/core_seq_pkg.sv
// Shared definitions for the core_seq control sequencer: FSM state encoding,
// RV32 opcode constants, instruction classes and the control-strobe decoder.
package core_seq_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5,
    StErr    = 3'd6
  } state_e;

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;

  typedef enum logic [1:0] {
    ClsAlu   = 2'd0,
    ClsLoad  = 2'd1,
    ClsStore = 2'd2,
    ClsBad   = 2'd3
  } cls_e;

  typedef struct packed {
    logic rom_en;
    logic ir_en;
    logic pc_en;
    logic reg_we;
    logic ram_re;
    logic ram_we;
    logic wdata_sel;
    logic retire;
  } ctrl_t;

  // Map a latched opcode onto the instruction class the FSM cares about.
  function automatic cls_e classify(logic [6:0] opc);
    cls_e cls;
    case (opc)
      OpcOp, OpcOpImm: cls = ClsAlu;
      OpcLoad:         cls = ClsLoad;
      OpcStore:        cls = ClsStore;
      default:         cls = ClsBad;
    endcase
    return cls;
  endfunction

  // Datapath control decode from the current state and the latched instruction.
  // halt_req only gates the fetch strobes; mem_ready only selects the store
  // completion strobes in MEM.
  function automatic ctrl_t ctrl_decode(state_e st, cls_e cls, logic rd_nz,
                                        logic halt_req, logic mem_ready);
    ctrl_t c;
    c = '0;
    case (st)
      StFetch: begin
        if (!halt_req) begin
          c.rom_en = 1'b1;
          c.ir_en  = 1'b1;
        end
      end
      StMem: begin
        c.ram_re = (cls == ClsLoad);
        c.ram_we = (cls == ClsStore);
        // A store has nothing to write back, so it completes in MEM.
        if (mem_ready && (cls == ClsStore)) begin
          c.pc_en  = 1'b1;
          c.retire = 1'b1;
        end
      end
      StWb: begin
        c.reg_we    = rd_nz;
        c.pc_en     = 1'b1;
        c.retire    = 1'b1;
        c.wdata_sel = (cls == ClsLoad);
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/core_seq_cnt.sv
// Free-running cycle counter and retired-instruction counter, both wrapping.
module core_seq_cnt #(
  parameter int unsigned CntW = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            retire_i,
  output logic [CntW-1:0] cycle_cnt_o,
  output logic [CntW-1:0] instret_cnt_o
);

  logic [CntW-1:0] cycle_q, cycle_d;
  logic [CntW-1:0] instret_q, instret_d;

  // Next counter values; both wrap naturally at 2^CntW.
  always_comb begin
    cycle_d   = cycle_q + CntW'(1);
    instret_d = instret_q;
    if (retire_i) begin
      instret_d = instret_q + CntW'(1);
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt_o   = cycle_q;
  assign instret_cnt_o = instret_q;

endmodule

// File: rtl/core_seq.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> [WB],
// with halt at instruction boundaries, a bounded memory wait and a sticky
// error state.
module core_seq
  import core_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             rom_en,
  output logic             ir_en,
  output logic             pc_en,
  output logic             reg_we,
  output logic             ram_re,
  output logic             ram_we,
  output logic             wdata_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             err,
  output logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  // Last wait count tolerated; one more idle MEM cycle means timeout.
  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  // Only the opcode and rd fields of the instruction are needed here.
  logic [11:0] ir_q;
  cls_e        cls;
  logic        rd_nz;
  ctrl_t       ctrl;

  logic unused_inst;
  assign unused_inst = ^inst[31:12];

  assign cls   = classify(ir_q[6:0]);
  assign rd_nz = |ir_q[11:7];

  // Next-state and memory wait counter.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      StFetch:  state_d = halt_req ? StHalt : StDecode;
      StDecode: state_d = (cls == ClsBad) ? StErr : StExec;
      StExec:   state_d = (cls == ClsAlu) ? StWb : StMem;
      StMem: begin
        if (mem_ready) begin
          state_d = (cls == ClsLoad) ? StWb : StFetch;
        end else if (wait_q == WaitLast) begin
          state_d = StErr;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StWb:     state_d = StFetch;
      StHalt:   state_d = halt_req ? StHalt : StFetch;
      StErr:    state_d = StErr;
      default:  state_d = StErr;
    endcase
  end

  // Control strobes; reset forces everything quiet in the reset cycle too.
  always_comb begin
    ctrl = ctrl_decode(state_q, cls, rd_nz, halt_req, mem_ready);
    if (rst) begin
      ctrl = '0;
    end
  end

  // State, wait counter and instruction register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      wait_q  <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (ctrl.ir_en) begin
        ir_q <= inst[11:0];
      end
    end
  end

  core_seq_cnt #(
    .CntW (CNT_W)
  ) u_cnt (
    .clk_i         (clk),
    .rst_i         (rst),
    .retire_i      (ctrl.retire),
    .cycle_cnt_o   (cycle_cnt),
    .instret_cnt_o (instret_cnt)
  );

  assign rom_en    = ctrl.rom_en;
  assign ir_en     = ctrl.ir_en;
  assign pc_en     = ctrl.pc_en;
  assign reg_we    = ctrl.reg_we;
  assign ram_re    = ctrl.ram_re;
  assign ram_we    = ctrl.ram_we;
  assign wdata_sel = ctrl.wdata_sel;
  assign retire    = ctrl.retire;
  assign state     = state_q;
  assign halted    = !rst && (state_q == StHalt);
  assign err       = !rst && (state_q == StErr);

endmodule

// File: tb/tb_core_seq.sv
// Self-checking bench for core_seq: directed scenarios plus randomized
// instruction streams against a latency/strobe-count reference model.
module tb_core_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = '0;
  logic        mem_ready = 1'b0;
  logic        halt_req = 1'b0;

  logic        rom_en, ir_en, pc_en, reg_we, ram_re, ram_we, wdata_sel;
  logic [2:0]  state;
  logic        halted, err, retire;
  logic [31:0] cycle_cnt, instret_cnt;

  logic        rom_en4, ir_en4, pc_en4, reg_we4, ram_re4, ram_we4, wdata_sel4;
  logic [2:0]  state4;
  logic        halted4, err4, retire4;
  logic [3:0]  cycle_cnt4, instret_cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  core_seq dut (
    .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready), .halt_req(halt_req),
    .rom_en(rom_en), .ir_en(ir_en), .pc_en(pc_en), .reg_we(reg_we), .ram_re(ram_re),
    .ram_we(ram_we), .wdata_sel(wdata_sel), .state(state), .halted(halted), .err(err),
    .retire(retire), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  core_seq #(.MEM_TIMEOUT(15), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready), .halt_req(halt_req),
    .rom_en(rom_en4), .ir_en(ir_en4), .pc_en(pc_en4), .reg_we(reg_we4), .ram_re(ram_re4),
    .ram_we(ram_we4), .wdata_sel(wdata_sel4), .state(state4), .halted(halted4), .err(err4),
    .retire(retire4), .cycle_cnt(cycle_cnt4), .instret_cnt(instret_cnt4)
  );

  always #5 clk = ~clk;

  // All tasks start and end at a falling-edge instant; inputs are driven
  // there and outputs sampled 1 time unit later.

  task automatic apply_reset();
    rst = 1'b1;
    halt_req = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one instruction from FETCH until it retires (or errors / times out),
  // holding mem_ready low for the first w memory-strobe cycles.
  task automatic exec_instr(input logic [31:0] ins, input int w, output int cyc,
                            output int n_re, output int n_we, output int n_rw,
                            output int n_ret, output int n_pc, output int n_bad,
                            output logic wsel, output logic [31:0] cnt_at_ret,
                            output logic [31:0] span);
    int mcnt;
    bit done;
    logic [31:0] c0;
    mcnt = 0; cyc = 0; n_re = 0; n_we = 0; n_rw = 0; n_ret = 0; n_pc = 0; n_bad = 0;
    wsel = 1'b0; cnt_at_ret = '0; span = '0; done = 1'b0; c0 = '0;
    inst = ins;
    halt_req = 1'b0;
    while (!done && cyc < 64) begin
      mem_ready = (mcnt >= w);
      #1;
      if (cyc == 0) c0 = cycle_cnt;
      cyc++;
      if (ram_re || ram_we) mcnt++;
      n_re  += int'(ram_re);
      n_we  += int'(ram_we);
      n_rw  += int'(reg_we);
      n_ret += int'(retire);
      n_pc  += int'(pc_en);
      if ((int'(pc_en) + int'(ram_re) + int'(ram_we) + int'(reg_we)) > 1 &&
          !(pc_en && (reg_we ^ ram_we) && !ram_re)) n_bad++;
      if (retire) begin
        wsel = wdata_sel;
        cnt_at_ret = instret_cnt;
        span = cycle_cnt - c0;
        done = 1'b1;
      end
      if (err) done = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    n_checks++;
    if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", cycle_cnt, instret_cnt);
    end
    n_checks++;
    if ({rom_en, ir_en, pc_en, reg_we, ram_re, ram_we, wdata_sel, halted, err, retire} !== 10'd0)
    begin
      n_fail++; $display("FAIL reset_strobes got nonzero want all 0");
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd0 || rom_en !== 1'b1 || cycle_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_release state=%0d rom_en=%0b cnt=%0d want 0/1/0",
                         state, rom_en, cycle_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    int cyc, n_re, n_we, n_rw, n_ret, n_pc, n_bad;
    logic wsel;
    logic [31:0] cr, sp;
    apply_reset();
    exec_instr(32'h003100B3, 0, cyc, n_re, n_we, n_rw, n_ret, n_pc, n_bad, wsel, cr, sp);
    n_checks++;
    if (cyc !== 4) begin n_fail++; $display("FAIL add_latency got %0d want 4", cyc); end
    n_checks++;
    if (n_rw !== 1 || n_pc !== 1 || n_ret !== 1) begin
      n_fail++; $display("FAIL add_strobes reg_we=%0d pc_en=%0d retire=%0d want 1/1/1",
                         n_rw, n_pc, n_ret);
    end
    #1;
    n_checks++;
    if (instret_cnt !== 32'd1) begin
      n_fail++; $display("FAIL add_instret got %0d want 1", instret_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_load_wait();
    int cyc, n_re, n_we, n_rw, n_ret, n_pc, n_bad;
    logic wsel;
    logic [31:0] cr, sp;
    apply_reset();
    exec_instr(32'h00012083, 3, cyc, n_re, n_we, n_rw, n_ret, n_pc, n_bad, wsel, cr, sp);
    n_checks++;
    if (cyc !== 8) begin n_fail++; $display("FAIL lw_latency got %0d want 8", cyc); end
    n_checks++;
    if (n_re !== 4) begin n_fail++; $display("FAIL lw_ram_re got %0d want 4", n_re); end
    n_checks++;
    if (wsel !== 1'b1 || n_rw !== 1) begin
      n_fail++; $display("FAIL lw_wb wdata_sel=%0b reg_we=%0d want 1/1", wsel, n_rw);
    end
  endtask

  task automatic test_x0();
    int cyc, n_re, n_we, n_rw, n_ret, n_pc, n_bad;
    logic wsel;
    logic [31:0] cr, sp;
    apply_reset();
    exec_instr(32'h00000013, 0, cyc, n_re, n_we, n_rw, n_ret, n_pc, n_bad, wsel, cr, sp);
    n_checks++;
    if (n_rw !== 0 || n_ret !== 1 || cyc !== 4) begin
      n_fail++; $display("FAIL addi_x0 reg_we=%0d retire=%0d cyc=%0d want 0/1/4",
                         n_rw, n_ret, cyc);
    end
  endtask

  task automatic test_timeout();
    int n_we = 0, n_mem = 0, n_ret = 0;
    bit seen_err = 1'b0;
    apply_reset();
    inst = 32'h00112023;
    for (int k = 0; k < 40 && !seen_err; k++) begin
      mem_ready = 1'b0;
      #1;
      n_we  += int'(ram_we);
      n_mem += int'(state == 3'd3);
      n_ret += int'(retire);
      if (err) seen_err = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (!seen_err) begin n_fail++; $display("FAIL timeout_err got 0 want 1"); end
    n_checks++;
    if (n_we !== 15 || n_mem !== 15) begin
      n_fail++; $display("FAIL timeout_mem_cycles ram_we=%0d mem=%0d want 15/15", n_we, n_mem);
    end
    n_checks++;
    if (n_ret !== 0) begin n_fail++; $display("FAIL timeout_retire got %0d want 0", n_ret); end
    for (int k = 0; k < 4; k++) begin
      mem_ready = 1'b1;
      halt_req = k[0];
      #1;
      n_checks++;
      if (err !== 1'b1 || state !== 3'd6 || {ram_we, ram_re, pc_en, retire} !== 4'd0) begin
        n_fail++; $display("FAIL timeout_sticky[%0d] err=%0b state=%0d want 1/6", k, err, state);
      end
      @(negedge clk);
    end
    apply_reset();
    #1;
    n_checks++;
    if (err !== 1'b0 || state !== 3'd0) begin
      n_fail++; $display("FAIL timeout_rst_clear err=%0b state=%0d want 0/0", err, state);
    end
    @(negedge clk);
  endtask

  task automatic test_halt();
    bit saw_ret = 1'b0;
    apply_reset();
    inst = 32'h00100293;
    for (int k = 0; k < 20 && !saw_ret; k++) begin
      if (state == 3'd2) halt_req = 1'b1;
      #1;
      if (retire) saw_ret = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (!saw_ret || halt_req !== 1'b1) begin
      n_fail++; $display("FAIL halt_retire got %0b want 1", saw_ret);
    end
    #1;
    n_checks++;
    if (state !== 3'd0 || rom_en !== 1'b0 || ir_en !== 1'b0) begin
      n_fail++; $display("FAIL halt_fetch state=%0d rom_en=%0b want 0/0", state, rom_en);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (state !== 3'd5 || halted !== 1'b1 ||
          {rom_en, ir_en, pc_en, reg_we, ram_re, ram_we, retire} !== 7'd0) begin
        n_fail++; $display("FAIL halt_hold[%0d] state=%0d halted=%0b want 5/1", k, state, halted);
      end
    end
    @(negedge clk);
    halt_req = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd5) begin n_fail++; $display("FAIL halt_release_same got %0d want 5", state); end
    @(negedge clk);
    #1;
    n_checks++;
    if (state !== 3'd0 || halted !== 1'b0 || rom_en !== 1'b1 || instret_cnt !== 32'd1) begin
      n_fail++; $display("FAIL halt_resume state=%0d halted=%0b instret=%0d want 0/0/1",
                         state, halted, instret_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_bad_opcode();
    int want_state [3] = '{0, 1, 6};
    apply_reset();
    inst = 32'h0000007F;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (int'(state) !== want_state[k]) begin
        n_fail++; $display("FAIL badop_state[%0d] got %0d want %0d", k, state, want_state[k]);
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL badop_err got %0b want 1", err); end
    @(negedge clk);
  endtask

  task automatic test_rst_mid_mem();
    int n_ret = 0;
    logic last_we = 1'b0;
    logic [2:0] last_state = '0;
    apply_reset();
    inst = 32'h00112023;
    mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_ret += int'(retire);
      last_we = ram_we;
      last_state = state;
      @(negedge clk);
    end
    n_checks++;
    if (last_we !== 1'b1 || last_state !== 3'd3) begin
      n_fail++; $display("FAIL rstmem_setup ram_we=%0b state=%0d want 1/3", last_we, last_state);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (ram_we !== 1'b0 || state !== 3'd0 || retire !== 1'b0 || instret_cnt !== 32'd0 ||
        n_ret !== 0) begin
      n_fail++; $display("FAIL rstmem ram_we=%0b state=%0d instret=%0d want 0/0/0",
                         ram_we, state, instret_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_cnt_wrap();
    apply_reset();
    halt_req = 1'b1;
    repeat (17) @(negedge clk);
    #1;
    n_checks++;
    if (cycle_cnt4 !== 4'd1) begin
      n_fail++; $display("FAIL wrap_cnt4 got %0d want 1", cycle_cnt4);
    end
    n_checks++;
    if (cycle_cnt !== 32'd17) begin
      n_fail++; $display("FAIL wrap_cnt32 got %0d want 17", cycle_cnt);
    end
    @(negedge clk);
    halt_req = 1'b0;
  endtask

  task automatic test_random_stream();
    logic [6:0] opcs [4] = '{7'h33, 7'h13, 7'h03, 7'h23};
    int mdl_instret = 0;
    apply_reset();
    for (int i = 0; i < 24; i++) begin
      int cyc, n_re, n_we, n_rw, n_ret, n_pc, n_bad, w, exp_cyc, exp_re, exp_we, exp_rw;
      logic wsel;
      logic [31:0] cr, sp, r, ins;
      bit is_load, is_store;
      r = $urandom();
      ins = {r[31:7], opcs[$urandom_range(0, 3)]};
      w = int'($urandom_range(0, 6));
      is_load  = (ins[6:0] == 7'h03);
      is_store = (ins[6:0] == 7'h23);
      exp_cyc = is_load ? 5 + w : (is_store ? 4 + w : 4);
      exp_re  = is_load ? w + 1 : 0;
      exp_we  = is_store ? w + 1 : 0;
      exp_rw  = (!is_store && ins[11:7] != 5'd0) ? 1 : 0;
      exec_instr(ins, w, cyc, n_re, n_we, n_rw, n_ret, n_pc, n_bad, wsel, cr, sp);
      n_checks++;
      if (cyc !== exp_cyc) begin
        n_fail++; $display("FAIL rand[%0d] latency ins=%08h got %0d want %0d", i, ins, cyc, exp_cyc);
      end
      n_checks++;
      if (n_re !== exp_re || n_we !== exp_we) begin
        n_fail++; $display("FAIL rand[%0d] ram ins=%08h re=%0d we=%0d want %0d/%0d",
                           i, ins, n_re, n_we, exp_re, exp_we);
      end
      n_checks++;
      if (n_rw !== exp_rw) begin
        n_fail++; $display("FAIL rand[%0d] reg_we ins=%08h got %0d want %0d", i, ins, n_rw, exp_rw);
      end
      n_checks++;
      if (n_ret !== 1 || n_pc !== 1 || n_bad !== 0) begin
        n_fail++; $display("FAIL rand[%0d] retire/pc/excl got %0d/%0d/%0d want 1/1/0",
                           i, n_ret, n_pc, n_bad);
      end
      n_checks++;
      if (wsel !== logic'(is_load)) begin
        n_fail++; $display("FAIL rand[%0d] wdata_sel got %0b want %0b", i, wsel, is_load);
      end
      n_checks++;
      if (cr !== 32'(mdl_instret) || sp !== 32'(exp_cyc - 1)) begin
        n_fail++; $display("FAIL rand[%0d] counters instret=%0d span=%0d want %0d/%0d",
                           i, cr, sp, mdl_instret, exp_cyc - 1);
      end
      mdl_instret++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_load_wait();
    test_x0();
    test_timeout();
    test_halt();
    test_bad_opcode();
    test_rst_mid_mem();
    test_cnt_wrap();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
